// File: rtl/fc_pkg.sv
// Shared types and default sizing for the fully-connected layer blocks.
package fc_pkg;

    localparam int N_IN_DEF    = 8;
    localparam int N_OUT_DEF   = 4;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

    typedef logic signed [DW_DEF-1:0] data_t;

endpackage

// File: rtl/fc_layer_seq_if.sv
// Buffer and dot-product side signals of the layer sequencer.
interface fc_layer_seq_if
    import fc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int DW    = DW_DEF
);
    localparam int AW = $clog2(N_IN);
    localparam int NW = $clog2(N_OUT);

    logic                 act_rd_en;
    logic [AW-1:0]        act_addr;
    logic signed [DW-1:0] act_data;
    logic                 dp_in_valid;
    logic signed [DW-1:0] dp_in_data;
    logic                 dp_first;
    logic [NW-1:0]        dp_neuron;
    logic signed [DW-1:0] dp_out_data;
    logic                 dp_out_valid;
    logic                 res_wr_en;
    logic [NW-1:0]        res_addr;
    logic signed [DW-1:0] res_data;

    modport master (
        output act_rd_en, act_addr, dp_in_valid, dp_in_data, dp_first, dp_neuron,
               res_wr_en, res_addr, res_data,
        input  act_data, dp_out_data, dp_out_valid
    );

    modport slave (
        input  act_rd_en, act_addr, dp_in_valid, dp_in_data, dp_first, dp_neuron,
               res_wr_en, res_addr, res_data,
        output act_data, dp_out_data, dp_out_valid
    );

endinterface

// File: rtl/fc_layer_seq.sv
// Runs one activation vector through fc_dotprod per output neuron and
// stores each scalar result in the result buffer.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    fc_layer_seq_if.master bus
);
    localparam int AW = $clog2(N_IN);
    localparam int NW = $clog2(N_OUT);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [AW-1:0]        elem_q;
    logic [NW-1:0]        neuron_q;
    logic [TW-1:0]        tcnt_q;
    logic                 err_q, done_q, rd_en;
    logic                 in_vld_q, first_q, wr_en_q;
    logic [NW-1:0]        res_addr_q;
    logic signed [DW-1:0] res_data_q;

    wire last_elem   = (elem_q == AW'(N_IN - 1));
    wire last_neuron = (neuron_q == NW'(N_OUT - 1));
    wire tmo         = (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM: begin
                rd_en = 1'b1;
                if (last_elem) state_d = WAIT;
            end
            WAIT: begin
                if (bus.dp_out_valid) state_d = last_neuron ? DONE : STREAM;
                else if (tmo)         state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            elem_q     <= '0;
            neuron_q   <= '0;
            tcnt_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            in_vld_q   <= 1'b0;
            first_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= (state_q == DONE);
            wr_en_q  <= 1'b0;
            // Buffer read data lands one cycle after the strobe; tag it here.
            in_vld_q <= rd_en;
            first_q  <= rd_en && (elem_q == '0);
            case (state_q)
                IDLE: if (start) begin
                    neuron_q <= '0;
                    elem_q   <= '0;
                    err_q    <= 1'b0;
                end
                STREAM: begin
                    elem_q <= last_elem ? '0 : elem_q + AW'(1);
                    tcnt_q <= '0;
                end
                WAIT: begin
                    if (bus.dp_out_valid) begin
                        wr_en_q    <= 1'b1;
                        res_addr_q <= neuron_q;
                        res_data_q <= bus.dp_out_data;
                        elem_q     <= '0;
                        if (!last_neuron) neuron_q <= neuron_q + NW'(1);
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign err             = err_q;
    assign bus.act_rd_en   = rd_en;
    assign bus.act_addr    = elem_q;
    assign bus.dp_in_valid = in_vld_q;
    assign bus.dp_in_data  = in_vld_q ? bus.act_data : '0;
    assign bus.dp_first    = first_q;
    assign bus.dp_neuron   = neuron_q;
    assign bus.res_wr_en   = wr_en_q;
    assign bus.res_addr    = res_addr_q;
    assign bus.res_data    = res_data_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: buffer and dot-product models, write scoreboard.
module tb_fc_layer_seq;
    import fc_pkg::*;

    localparam int N_IN = 8, N_OUT = 4, DW = 8, TIMEOUT = 64, L = 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, done, err;

    fc_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

    fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    wr_t   sb[$];
    int    vectors = 0, miscompares = 0;
    int    done_cnt = 0, wr_cnt = 0, wait_cnt = 0;
    int    eidx = 0, nref = 0, elem_seen = 0;
    bit    chk_elem = 1'b0;
    data_t act_mem[N_IN];
    int    silent = -1;
    logic  spur = 1'b0, model_vld = 1'b0;
    int    ecnt = 0, pend = 0, pn = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // activation buffer: one-cycle read latency, junk when not reading
    always @(posedge clk) begin
        if (rst) bus.act_data <= '0;
        else     bus.act_data <= bus.act_rd_en ? act_mem[bus.act_addr] : data_t'(85);
    end

    // dotprod model: answers 40+neuron L cycles after the last element
    assign bus.dp_out_valid = model_vld | spur;
    always @(posedge clk) begin
        model_vld <= 1'b0;
        if (rst) begin
            pend <= 0;
            ecnt <= 0;
            bus.dp_out_data <= '0;
        end else begin
            if (pend == 1) begin
                model_vld       <= 1'b1;
                bus.dp_out_data <= DW'(40 + pn);
            end
            if (pend > 0) pend <= pend - 1;
            if (bus.dp_in_valid) begin
                ecnt <= (bus.dp_first ? 0 : ecnt) + 1;
                if ((bus.dp_first ? 0 : ecnt) == N_IN - 1 && int'(bus.dp_neuron) != silent) begin
                    pend <= L - 1;
                    pn   <= int'(bus.dp_neuron);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bus.act_rd_en)     wait_cnt = 0;
        else if (busy && !err) wait_cnt++;
        if (bus.res_wr_en) begin
            wr_cnt++;
            if (sb.size() == 0) chk("extra_wr", int'(bus.res_wr_en), 0);
            else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", int'(bus.res_addr), e.addr);
                chk("wr_data", int'(bus.res_data), e.data);
            end
        end
        if (chk_elem && bus.dp_in_valid) begin
            chk("elem", int'(bus.dp_in_data), int'(act_mem[eidx]));
            chk("first", int'(bus.dp_first), int'(eidx == 0));
            if (eidx == 0) nref = int'(bus.dp_neuron);
            else chk("neuron_stable", int'(bus.dp_neuron), nref);
            eidx = (eidx + 1) % N_IN;
            elem_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_rd_en"}, int'(bus.act_rd_en), 0);
        chk({tag, "_in_vld"}, int'(bus.dp_in_valid), 0);
        chk({tag, "_first"}, int'(bus.dp_first), 0);
        chk({tag, "_wr_en"}, int'(bus.res_wr_en), 0);
        chk({tag, "_act_addr"}, int'(bus.act_addr), 0);
        chk({tag, "_in_data"}, int'(bus.dp_in_data), 0);
        chk({tag, "_neuron"}, int'(bus.dp_neuron), 0);
        chk({tag, "_res_addr"}, int'(bus.res_addr), 0);
        chk({tag, "_res_data"}, int'(bus.res_data), 0);
    endtask

    // push expected writes, pulse start, check the first two cycles of the run
    task automatic run_layer(input int sil);
        for (int n = 0; n < N_OUT; n++)
            if (sil < 0 || n < sil) sb.push_back('{n, 40 + n});
        silent = sil;
        start  = 1'b1;
        cyc(1);
        start  = 1'b0;
        chk("c1_busy", int'(busy), 1);
        chk("c1_rd_en", int'(bus.act_rd_en), 1);
        chk("c1_addr", int'(bus.act_addr), 0);
        chk("c1_err_clr", int'(err), 0);
        cyc(1);
        chk("c2_in_vld", int'(bus.dp_in_valid), 1);
        chk("c2_first", int'(bus.dp_first), 1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) cyc(1);
        if (done_cnt == d0) chk("done_tmo", 0, 1);
    endtask

    initial begin
        int d0, w0, k;
        for (int i = 0; i < N_IN; i++) act_mem[i] = data_t'(16);
        cyc(3);
        check_zero("rst");
        rst = 1'b0;
        cyc(2);

        // spurious result while idle
        spur = 1'b1;
        cyc(1);
        spur = 1'b0;
        cyc(2);
        chk("spur_idle_busy", int'(busy), 0);
        chk("spur_idle_wr", wr_cnt, 0);

        // basic run
        d0 = done_cnt; w0 = wr_cnt;
        run_layer(-1);
        wait_done(400);
        cyc(3);
        chk("basic_done", done_cnt - d0, 1);
        chk("basic_wr", wr_cnt - w0, 4);
        chk("basic_err", int'(err), 0);
        chk("basic_sb", sb.size(), 0);

        // ramp sequencing plus a spurious result mid-stream
        for (int i = 0; i < N_IN; i++) act_mem[i] = data_t'(i - 4);
        chk_elem = 1'b1; eidx = 0; elem_seen = 0;
        d0 = done_cnt; w0 = wr_cnt;
        run_layer(-1);
        cyc(1);
        spur = 1'b1;
        cyc(1);
        spur = 1'b0;
        wait_done(400);
        cyc(3);
        chk_elem = 1'b0;
        chk("ramp_elems", elem_seen, N_IN * N_OUT);
        chk("ramp_wr", wr_cnt - w0, 4);
        chk("ramp_sb", sb.size(), 0);

        // neuron 2 never answers
        d0 = done_cnt; w0 = wr_cnt;
        run_layer(2);
        wait_done(600);
        chk("tmo_cycles", wait_cnt, TIMEOUT);
        chk("tmo_err", int'(err), 1);
        cyc(10);
        chk("tmo_err_sticky", int'(err), 1);
        chk("tmo_done", done_cnt - d0, 1);
        chk("tmo_wr", wr_cnt - w0, 2);
        chk("tmo_sb", sb.size(), 0);

        // start pulses mid-stream and in the DONE cycle
        d0 = done_cnt; w0 = wr_cnt;
        run_layer(-1);
        cyc(2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        k = 0;
        while (!(bus.res_wr_en && bus.res_addr == 2'd3) && k < 400) begin
            cyc(1);
            k++;
        end
        chk("busy_last_wr_seen", int'(bus.res_wr_en), 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        chk("busy_idle", int'(busy), 0);
        chk("busy_done", done_cnt - d0, 1);
        chk("busy_wr", wr_cnt - w0, 4);
        chk("busy_sb", sb.size(), 0);

        // reset while waiting on neuron 1
        w0 = wr_cnt;
        run_layer(1);
        k = 0;
        while (!(busy && bus.dp_neuron == 2'd1 && !bus.act_rd_en && !bus.dp_in_valid) && k < 200) begin
            cyc(1);
            k++;
        end
        chk("mid_wait_seen", int'(bus.dp_neuron), 1);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check_zero("midrst");
        rst = 1'b0;
        cyc(5);
        chk("midrst_wr", wr_cnt - w0, 1);
        chk("midrst_idle", int'(busy), 0);
        chk("midrst_sb", sb.size(), 0);

        d0 = done_cnt; w0 = wr_cnt;
        run_layer(-1);
        wait_done(400);
        cyc(3);
        chk("rerun_done", done_cnt - d0, 1);
        chk("rerun_wr", wr_cnt - w0, 4);
        chk("rerun_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
